// File: rtl/uart_pkg.sv
// Shared UART link definitions: frame state encoding and default framing
// parameters, used by both the transmitter and the receiver so the two ends agree.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_WIDTH        = 8;
    localparam int UART_CLKS_PER_BIT = 8;
    localparam int UART_STOP_BITS    = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last
// cycle of each bit period. clear holds it at zero (combinational tick, no backpressure).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits MSB-first, STOP_BITS stop bits; all outputs
// registered, first start bit one clock after the transfer edge. UART_TX_HOLD_BUF_EN adds a one-word holding register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = UART_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = UART_STOP_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] tx_pi,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_so,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int BCW = $clog2(WIDTH + 1);

    uart_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             tx_so_q, tx_so_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_ready_q, tx_ready_d;
    logic             load;
    logic [WIDTH-1:0] load_dat;
    logic             xfer;
    logic             tick;
`ifdef UART_TX_HOLD_BUF_EN
    logic             hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0] hold_q, hold_d;
`endif

    assign xfer = tx_valid && tx_ready_q && en;

    // Baud counter idles at zero so the start bit always gets a full period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state_q == IDLE) || !en),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_done_d = 1'b0;
        load      = 1'b0;
        load_dat  = tx_pi;
`ifdef UART_TX_HOLD_BUF_EN
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
`endif
        if (!en) begin
            state_d = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
            hold_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) load = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                    // tx_ready is low while the holding register is full, so no clash with xfer.
                    if (hold_vld_q) begin
                        load       = 1'b1;
                        load_dat   = hold_q;
                        hold_vld_d = 1'b0;
                    end
`endif
                end
                START: begin
                    if (tick) state_d = DATA;
                end
                DATA: begin
                    if (tick) begin
                        shift_d = shift_q << 1;
                        if (bit_cnt_q == BCW'(1)) begin
                            state_d   = STOP;
                            bit_cnt_d = BCW'(STOP_BITS);
                        end else begin
                            bit_cnt_d = bit_cnt_q - BCW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == BCW'(1)) begin
                            state_d   = IDLE;
                            tx_done_d = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                            if (hold_vld_q) begin
                                load       = 1'b1;
                                load_dat   = hold_q;
                                hold_vld_d = 1'b0;
                            end
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q - BCW'(1);
                        end
                    end
                end
            endcase
            if (load) begin
                state_d   = START;
                shift_d   = load_dat;
                bit_cnt_d = BCW'(WIDTH);
            end
`ifdef UART_TX_HOLD_BUF_EN
            if (xfer && state_q != IDLE) begin
                hold_d     = tx_pi;
                hold_vld_d = 1'b1;
            end
`endif
        end

        tx_so_d = 1'b1;
        case (state_d)
            START:   tx_so_d = 1'b0;
            DATA:    tx_so_d = shift_d[WIDTH-1];
            default: tx_so_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
`ifdef UART_TX_HOLD_BUF_EN
        tx_ready_d = en && !hold_vld_d;
`else
        tx_ready_d = en && (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tx_so_q    <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_so_q    <= tx_so_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            tx_ready_q <= tx_ready_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end
`endif

    assign tx_so    = tx_so_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame vectors checked bit-by-bit over every cycle,
// plus back-to-back, abort, reset and holding-register sequences.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] tx_pi;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_so;
    logic       tx_busy;
    logic       tx_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(8), .STOP_BITS(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .tx_pi    (tx_pi),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_so    (tx_so),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    typedef struct {
        logic [7:0] dat;
        logic [9:0] line;   // expected line levels, first bit in [9]
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Waits for tx_ready, then transfers d; returns positioned in the first start-bit cycle.
    task automatic send(input logic [7:0] d, input bit keep_valid);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("ready_timeout", 32'(tx_ready), 32'd1);
        tx_pi    = d;
        tx_valid = 1'b1;
        step();
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Checks all 80 cycles of a frame; returns positioned in the cycle after the last stop cycle.
    task automatic check_frame(input logic [9:0] line, input string name, input bit drop_valid);
        for (int b = 0; b < 10; b++) begin
            logic bad;
            logic seen;
            bad  = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (tx_so !== line[9-b] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                    bad  = 1'b1;
                    seen = tx_so;
                end
                step();
                if (drop_valid && b == 0 && c == 0) tx_valid = 1'b0;
            end
            chk($sformatf("%s_bit%0d_err(so=%0b)", name, b, seen), 32'(bad), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{dat: 8'hA5, line: 10'b0_10100101_1};
        vecs[1] = '{dat: 8'h3C, line: 10'b0_00111100_1};
        vecs[2] = '{dat: 8'hFF, line: 10'b0_11111111_1};
        vecs[3] = '{dat: 8'h01, line: 10'b0_00000001_1};

        rst_n    = 1'b0;
        en       = 1'b1;
        tx_valid = 1'b0;
        tx_pi    = 8'h00;

        // Reset values
        repeat (3) step();
        chk("rst_so",    32'(tx_so),    32'd1);
        chk("rst_busy",  32'(tx_busy),  32'd0);
        chk("rst_done",  32'(tx_done),  32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(tx_ready), 32'd1);
        chk("idle_so",         32'(tx_so),    32'd1);

        // Table-driven single frames
        foreach (vecs[i]) begin
            send(vecs[i].dat, 1'b0);
            check_frame(vecs[i].line, $sformatf("vec%0d", i), 1'b0);
            chk($sformatf("vec%0d_done", i),  32'(tx_done),  32'd1);
            chk($sformatf("vec%0d_busy", i),  32'(tx_busy),  32'd0);
            chk($sformatf("vec%0d_ready", i), 32'(tx_ready), 32'd1);
            chk($sformatf("vec%0d_so", i),    32'(tx_so),    32'd1);
            step();
            chk($sformatf("vec%0d_done_pulse", i), 32'(tx_done), 32'd0);
        end

`ifndef UART_TX_HOLD_BUF_EN
        // Back-to-back with tx_valid held; tx_pi changes after the transfer edge
        send(8'h01, 1'b1);
        chk("b2b_ready_busy", 32'(tx_ready), 32'd0);
        tx_pi = 8'h80;
        check_frame(10'b0_00000001_1, "b2b_f1", 1'b0);
        chk("b2b_done1",  32'(tx_done),  32'd1);
        chk("b2b_ready1", 32'(tx_ready), 32'd1);
        step();
        tx_valid = 1'b0;
        check_frame(10'b0_10000000_1, "b2b_f2", 1'b0);
        chk("b2b_done2", 32'(tx_done), 32'd1);
        chk("b2b_busy2", 32'(tx_busy), 32'd0);

        // tx_valid while not ready is ignored
        send(8'hA5, 1'b0);
        repeat (5) step();
        tx_pi    = 8'h00;
        tx_valid = 1'b1;
        repeat (3) step();
        tx_valid = 1'b0;
        begin
            int n = 0;
            while (tx_done !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            chk("ign_done_seen", 32'(tx_done), 32'd1);
        end
        begin
            logic moved = 1'b0;
            for (int c = 0; c < 20; c++) begin
                step();
                if (tx_so !== 1'b1 || tx_busy !== 1'b0) moved = 1'b1;
            end
            chk("ign_no_extra_frame", 32'(moved), 32'd0);
        end
`else
        // Holding register: second word accepted while the first is shifting
        send(8'h12, 1'b1);
        chk("hold_ready_busy", 32'(tx_ready), 32'd1);
        tx_pi = 8'h34;
        check_frame(10'b0_00010010_1, "hold_f1", 1'b1);
        chk("hold_done1", 32'(tx_done), 32'd1);
        chk("hold_busy1", 32'(tx_busy), 32'd1);
        check_frame(10'b0_00110100_1, "hold_f2", 1'b0);
        chk("hold_done2", 32'(tx_done), 32'd1);
        chk("hold_busy2", 32'(tx_busy), 32'd0);
        step();
`endif

        // en dropped at cycle 30 of a frame
        send(8'hA5, 1'b0);
        repeat (30) step();
        en = 1'b0;
        step();
        chk("abort_so",    32'(tx_so),    32'd1);
        chk("abort_busy",  32'(tx_busy),  32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd0);
        chk("abort_done",  32'(tx_done),  32'd0);
        // tx_valid ignored while disabled
        tx_valid = 1'b1;
        begin
            logic moved = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (tx_so !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) moved = 1'b1;
            end
            chk("dis_ignores_valid", 32'(moved), 32'd0);
        end
        tx_valid = 1'b0;
        en = 1'b1;
        begin
            logic moved = 1'b0;
            for (int c = 0; c < 100; c++) begin
                step();
                if (tx_so !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) moved = 1'b1;
            end
            chk("abort_no_resume", 32'(moved), 32'd0);
        end
        chk("abort_ready_back", 32'(tx_ready), 32'd1);

        // Reset pulse mid-frame
        send(8'h00, 1'b0);
        repeat (20) step();
        chk("pre_rst_so", 32'(tx_so), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_so",   32'(tx_so),   32'd1);
        chk("async_rst_busy", 32'(tx_busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        begin
            logic moved = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (tx_so !== 1'b1 || tx_done !== 1'b0) moved = 1'b1;
                step();
            end
            chk("rst_no_resume", 32'(moved), 32'd0);
        end

        // Full frame still works after the reset
        send(8'h5A, 1'b0);
        check_frame(10'b0_01011010_1, "post_rst", 1'b0);
        chk("post_rst_done", 32'(tx_done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
